// File: rtl/shift_register_universal.sv
// Parametrised universal shift register: parallel load, bidirectional serial shift, bit counter, word strobe.
// Optional even-parity outputs (parity_out, word_parity) when SHIFT_REGISTER_PARITY_EN is defined.
module shift_register_universal #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       load_enable,
    input  logic                       shift_enable,
    input  logic                       shift_left,
    input  logic                       serial_in,
    input  logic [WIDTH-1:0]           parallel_in,
    output logic [WIDTH-1:0]           parallel_out,
    output logic                       serial_out,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       word_done
`ifdef SHIFT_REGISTER_PARITY_EN
    ,
    output logic                       parity_out,
    output logic                       word_parity
`endif
);

    localparam int                 COUNT_W    = $clog2(WIDTH + 1);
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   shift_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               done_d;

    // Priority: clear > load > shift > hold. word_done only survives one cycle.
    always_comb begin
        // NOTE: every signal gets a hold/default value before the priority chain, so no latch can be inferred.
        shift_d = shift_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (clear) begin
            shift_d = RESET_VALUE;
            count_d = '0;
        end else if (load_enable) begin
            shift_d = parallel_in;
            count_d = '0;
        end else if (shift_enable) begin
            if (shift_left) begin
                shift_d = {shift_q[WIDTH-2:0], serial_in};
            end else begin
                shift_d = {serial_in, shift_q[WIDTH-1:1]};
            end
            if (count_q == LAST_COUNT) begin
                count_d = '0;
                done_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q   <= RESET_VALUE;
            count_q   <= '0;
            word_done <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            count_q   <= count_d;
            word_done <= done_d;
        end
    end

    assign parallel_out = shift_q;
    assign bit_count    = count_q;
    assign serial_out   = shift_left ? shift_q[WIDTH-1] : shift_q[0];

`ifdef SHIFT_REGISTER_PARITY_EN
    assign parity_out = ^shift_q;

    // Captures the parity of the word that appears alongside word_done, then holds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_parity <= 1'b0;
        end else if (clear || load_enable) begin
            word_parity <= 1'b0;
        end else if (done_d) begin
            word_parity <= ^shift_d;
        end
    end
`endif

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench for shift_register_universal (WIDTH=8, RESET_VALUE=0): a reference model
// pushes expected state into a scoreboard queue as each step is driven; it is popped after the edge.
module tb_shift_register_universal;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             clear;
    logic             load_enable;
    logic             shift_enable;
    logic             shift_left;
    logic             serial_in;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] parallel_out;
    logic             serial_out;
    logic [3:0]       bit_count;
    logic             word_done;
`ifdef SHIFT_REGISTER_PARITY_EN
    logic             parity_out;
    logic             word_parity;
`endif

    shift_register_universal #(.WIDTH(WIDTH), .RESET_VALUE(8'h00)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (clear),
        .load_enable  (load_enable),
        .shift_enable (shift_enable),
        .shift_left   (shift_left),
        .serial_in    (serial_in),
        .parallel_in  (parallel_in),
        .parallel_out (parallel_out),
        .serial_out   (serial_out),
        .bit_count    (bit_count),
        .word_done    (word_done)
`ifdef SHIFT_REGISTER_PARITY_EN
        ,
        .parity_out   (parity_out),
        .word_parity  (word_parity)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] value;
        logic [3:0]       count;
        logic             done;
        logic             wpar;
    } expect_t;

    expect_t          scoreboard[$];
    int               total_checks = 0;
    int               passed_checks = 0;
    int               done_pulses = 0;

    logic [WIDTH-1:0] m_reg = 8'h00;
    logic [3:0]       m_cnt = 4'd0;
    logic             m_done = 1'b0;
    logic             m_wpar = 1'b0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic model_reset();
        m_reg  = 8'h00;
        m_cnt  = 4'd0;
        m_done = 1'b0;
        m_wpar = 1'b0;
    endtask

    // Drive one cycle of stimulus, predict the post-edge state, then compare after the edge.
    task automatic step(input string tag, input logic clr, input logic ld, input logic sh,
                        input logic left, input logic sin, input logic [WIDTH-1:0] pin);
        expect_t e;
        expect_t got;
        clear        = clr;
        load_enable  = ld;
        shift_enable = sh;
        shift_left   = left;
        serial_in    = sin;
        parallel_in  = pin;
        if (clr) begin
            m_reg = 8'h00; m_cnt = 4'd0; m_done = 1'b0; m_wpar = 1'b0;
        end else if (ld) begin
            m_reg = pin; m_cnt = 4'd0; m_done = 1'b0; m_wpar = 1'b0;
        end else if (sh) begin
            m_reg = left ? {m_reg[WIDTH-2:0], sin} : {sin, m_reg[WIDTH-1:1]};
            if (m_cnt == 4'(WIDTH - 1)) begin
                m_cnt = 4'd0; m_done = 1'b1; m_wpar = ^m_reg;
            end else begin
                m_cnt = m_cnt + 4'd1; m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
        end
        e.tag = tag; e.value = m_reg; e.count = m_cnt; e.done = m_done; e.wpar = m_wpar;
        scoreboard.push_back(e);
        @(posedge clock);
        #1;
        if (word_done === 1'b1) done_pulses++;
        got = scoreboard.pop_front();
        check({got.tag, ".parallel_out"}, 64'(parallel_out), 64'(got.value));
        check({got.tag, ".bit_count"}, 64'(bit_count), 64'(got.count));
        check({got.tag, ".word_done"}, 64'(word_done), 64'(got.done));
`ifdef SHIFT_REGISTER_PARITY_EN
        check({got.tag, ".parity_out"}, 64'(parity_out), 64'(^got.value));
        check({got.tag, ".word_parity"}, 64'(word_parity), 64'(got.wpar));
`endif
    endtask

    initial begin
        logic [7:0] right_bits;
        logic [7:0] left_serial;
        right_bits  = 8'b1010_0101;  // index i = i-th serial bit sent
        left_serial = 8'b0011_1100;  // index 7-i = serial_out expected before shift i

        reset_n = 1'b0; clear = 1'b0; load_enable = 1'b0; shift_enable = 1'b0;
        shift_left = 1'b0; serial_in = 1'b0; parallel_in = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset.parallel_out", 64'(parallel_out), 64'h00);
        check("reset.bit_count", 64'(bit_count), 64'd0);
        check("reset.word_done", 64'(word_done), 64'd0);
        check("reset.serial_out", 64'(serial_out), 64'd0);
        reset_n = 1'b1;

        // SIPO right shift of 1,0,1,0,0,1,0,1 assembles 0xA5.
        done_pulses = 0;
        for (int i = 0; i < 8; i++) step("sipo_right", 1'b0, 1'b0, 1'b1, 1'b0, right_bits[i], 8'h00);
        check("sipo_right.word", 64'(parallel_out), 64'hA5);
        check("sipo_right.strobe", 64'(word_done), 64'd1);
`ifdef SHIFT_REGISTER_PARITY_EN
        check("sipo_right.word_parity", 64'(word_parity), 64'd0);
`endif
        step("sipo_right.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("sipo_right.pulses", 64'(done_pulses), 64'd1);

        // PISO left shift of loaded 0x3C, serial_out checked before each shift.
        step("piso_load", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C);
        done_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            shift_left = 1'b1;
            #1;
            check($sformatf("piso_left.serial_out[%0d]", i), 64'(serial_out), 64'(left_serial[7-i]));
            step("piso_left", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        end
        check("piso_left.final", 64'(parallel_out), 64'h00);
        check("piso_left.pulses", 64'(done_pulses), 64'd1);

        // Load wins over a simultaneous shift and resets the count.
        step("pre_load", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        step("pre_load", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        step("load_vs_shift", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81);
        check("load_vs_shift.value", 64'(parallel_out), 64'h81);
        check("load_vs_shift.count", 64'(bit_count), 64'd0);

        // Mid-word asynchronous reset discards the partial word.
        for (int i = 0; i < 3; i++) step("pre_reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_reset.parallel_out", 64'(parallel_out), 64'h00);
        check("mid_reset.bit_count", 64'(bit_count), 64'd0);
        check("mid_reset.word_done", 64'(word_done), 64'd0);
        #1 reset_n = 1'b1;
        done_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step("post_reset", 1'b0, 1'b0, 1'b1, i[0], 1'b1, 8'h00);
            check("post_reset.strobe_pos", 64'(word_done), (i == 7) ? 64'd1 : 64'd0);
        end
        check("post_reset.pulses", 64'(done_pulses), 64'd1);

        // Gap in shifting: count holds, word completes on the 8th shift overall.
        done_pulses = 0;
        for (int i = 0; i < 5; i++) step("gap_first", 1'b0, 1'b0, 1'b1, 1'b1, i[1], 8'h00);
        for (int i = 0; i < 4; i++) begin
            step("gap_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            check("gap_hold.count", 64'(bit_count), 64'd5);
        end
        for (int i = 0; i < 3; i++) step("gap_last", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("gap_last.strobe", 64'(word_done), 64'd1);
        check("gap_last.pulses", 64'(done_pulses), 64'd1);

        // Clear beats load and shift.
        step("pre_clear", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        step("clear_all", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        check("clear_all.value", 64'(parallel_out), 64'h00);
        check("clear_all.count", 64'(bit_count), 64'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
